lsu: RTL and testbench
======================

# lsu

Load/store stage between the EX→LS pipeline register and write-back. Accepts one instruction per valid/ready handshake from the register's `m_*` outputs. Memory instructions run a single request/response transaction on a simple memory port; all others pass through. Presents the result to write-back through a second valid/ready handshake.

## Interface
- `XLEN`, 32: data/address width.
- `MASK_W`, 4: byte-lane mask width (`XLEN/8`).

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; asynchronous, active-low.
- `m_valid_i`  in  1  upstream instruction valid.
- `L_ready_o`  out  1  stage can accept; feeds the EX→LS register's `m_ready_i`.
- `m_wenReg_i`  in  1  register write enable.
- `m_rd_i`  in  5  destination register.
- `m_res_i`  in  XLEN  ALU result: effective address for loads/stores, else the value to write back.
- `m_src2_i`  in  XLEN  store data.
- `m_wenMem_i` / `m_renMem_i`  in  1  store / load.
- `m_mask_i`  in  MASK_W  access size, unshifted: 0001 byte, 0011 half, 1111 word.
- `m_is_load_signed_i`  in  1  sign-extend load data.
- `mem_req_valid_o`  out  1  memory request.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_req_addr_o`  out  XLEN  word-aligned address.
- `mem_req_wen_o`  out  1  request is a write.
- `mem_req_wdata_o`  out  XLEN  lane-shifted store data.
- `mem_req_wstrb_o`  out  MASK_W  lane-shifted byte strobes.
- `mem_resp_valid_i`  in  1  response (read data or write ack).
- `mem_resp_rdata_i`  in  XLEN  read data.
- `mem_resp_err_i`  in  1  bus error, qualified by `mem_resp_valid_i`.
- `l_valid_o`  out  1  result valid to write-back.
- `w_ready_i`  in  1  write-back accepts.
- `l_wenReg_o`  out  1  registered write enable.
- `l_rd_o`  out  5  registered destination register.
- `l_res_o`  out  XLEN  write-back value.
- `l_err_o`  out  1  misaligned access or bus error for this instruction.

## Operation
**FSM states:** IDLE, REQ, RESP, DONE.

**Accept** when `m_valid_i & L_ready_o`, with `L_ready_o = (IDLE) | (DONE & w_ready_i)`.
- On accept, capture all `m_*` fields.
- Compute `off = m_res_i[1:0]` and `strb = m_mask_i << off`.
- Misaligned: any bit of `m_mask_i` shifted beyond lane 3.

**Next state after accept:**
- Non-memory (`!m_wenMem_i & !m_renMem_i`) → DONE, with `l_res_o = m_res_i` and `l_err_o = 0`.
- Memory and misaligned → DONE, with `l_err_o = 1`, `l_res_o = m_res_i`, and no bus request.
- Memory and aligned → REQ.

**REQ**
- `mem_req_valid_o = 1`.
- `addr = {res[XLEN-1:2], 2'b00}`.
- `wen = wenMem`, `wstrb = strb`.
- `wdata = src2 << (8*off)`.
- Loads drive `wstrb = strb`, which is ignored by memory.
- Outputs are held stable until `mem_req_ready_i`, then → RESP.

**RESP**
- Wait for `mem_resp_valid_i`, then → DONE.
- Load: `sh = rdata >> (8*off)`. Byte/half results come from `sh[7:0]`/`sh[15:0]`, sign- or zero-extended per the `is_load_signed` flag. Word takes `sh` directly.
- Store: `l_res_o = res`, and `l_wenReg_o` is passed as captured.
- `l_err_o = mem_resp_err_i`. On error, load `l_res_o = 0`.

**DONE**
- `l_valid_o = 1`; all `l_*` outputs held stable.
- On `w_ready_i`: if a new instruction is accepted the same cycle, go to its next state; else → IDLE.

**Other rules**
- `mem_resp_valid_i` outside RESP is ignored.
- `m_valid_i` outside an accept cycle is ignored; upstream holds its data.

## Timing
**Reset** (async assert, sync release) → IDLE.
- All registered outputs 0: `l_valid_o`, `l_wenReg_o`, `l_rd_o`, `l_res_o`, `l_err_o`, `mem_req_*`.
- `L_ready_o = 1` out of reset.
- Reset mid-transaction abandons it; no request is reissued, and a late response is ignored in IDLE.

**Latency:**
- Non-memory or misaligned: `l_valid_o` rises 1 cycle after accept.
- Memory with zero-wait bus: accept → REQ (T+1) → RESP (T+2). With a response in that same cycle, DONE is at T+3.

**Throughput:** non-memory back-to-back sustains 1 instruction/cycle when `w_ready_i = 1`.

**`mem_req_valid_o`** is never deasserted before `mem_req_ready_i`; at most one request is outstanding.

**`l_valid_o`** is never deasserted before `w_ready_i`.

## Test plan
- **ALU pass-through:** `m_res_i = 0x1234`, `wenReg = 1`, `rd = 5`, `w_ready_i = 1` → `l_valid_o` 1 cycle after accept, `l_res_o = 0x1234`, `l_rd_o = 5`, no `mem_req_valid_o`; 3 back-to-back instructions complete in 3 consecutive cycles.
- **Signed byte load:** addr `0x80000003`, mask 0001, signed, rdata `0x85FFFFFF` → `mem_req_addr_o = 0x80000000`, `l_res_o = 0xFFFFFF85`. Unsigned variant → `0x00000085`.
- **Half store:** addr `0x102`, mask 0011, `src2 = 0xABCD` → `wstrb = 1100`, `wdata = 0xABCD0000`, `wen = 1`. `mem_req_ready_i` held low 3 cycles → request stays stable throughout.
- **Misaligned word load:** addr `0x101`, mask 1111 → no bus request, `l_err_o = 1` after 1 cycle. Bus error response on a load → `l_err_o = 1`, `l_res_o = 0`.
- **Backpressure:** `w_ready_i = 0` for 4 cycles in DONE → `l_*` outputs stable, `L_ready_o = 0`. Raising `w_ready_i` with `m_valid_i = 1` accepts the next instruction the same cycle.
- **Reset mid-transaction:** assert `rst_i` low during RESP → all outputs 0 immediately, IDLE after release; a late `mem_resp_valid_i` produces no `l_valid_o`.

Source files
------------

// File: rtl/lsu_if.sv
// Load/store stage bus bundle: upstream instruction handshake (m_*), memory
// request/response port (mem_*) and write-back handshake (l_*/w_ready_i).
// The lsu takes the slave side; the producer/consumer environment takes master.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int MASK_W = XLEN / 8
);
  // Upstream (EX->LS register outputs)
  logic              m_valid_i;
  logic              L_ready_o;
  logic              m_wenReg_i;
  logic [4:0]        m_rd_i;
  logic [XLEN-1:0]   m_res_i;
  logic [XLEN-1:0]   m_src2_i;
  logic              m_wenMem_i;
  logic              m_renMem_i;
  logic [MASK_W-1:0] m_mask_i;
  logic              m_is_load_signed_i;

  // Memory port
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [XLEN-1:0]   mem_req_addr_o;
  logic              mem_req_wen_o;
  logic [XLEN-1:0]   mem_req_wdata_o;
  logic [MASK_W-1:0] mem_req_wstrb_o;
  logic              mem_resp_valid_i;
  logic [XLEN-1:0]   mem_resp_rdata_i;
  logic              mem_resp_err_i;

  // Write-back
  logic              l_valid_o;
  logic              w_ready_i;
  logic              l_wenReg_o;
  logic [4:0]        l_rd_o;
  logic [XLEN-1:0]   l_res_o;
  logic              l_err_o;

  modport slave (
    input  m_valid_i, m_wenReg_i, m_rd_i, m_res_i, m_src2_i, m_wenMem_i,
           m_renMem_i, m_mask_i, m_is_load_signed_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_rdata_i, mem_resp_err_i,
           w_ready_i,
    output L_ready_o,
           mem_req_valid_o, mem_req_addr_o, mem_req_wen_o, mem_req_wdata_o,
           mem_req_wstrb_o,
           l_valid_o, l_wenReg_o, l_rd_o, l_res_o, l_err_o
  );

  modport master (
    output m_valid_i, m_wenReg_i, m_rd_i, m_res_i, m_src2_i, m_wenMem_i,
           m_renMem_i, m_mask_i, m_is_load_signed_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_rdata_i, mem_resp_err_i,
           w_ready_i,
    input  L_ready_o,
           mem_req_valid_o, mem_req_addr_o, mem_req_wen_o, mem_req_wdata_o,
           mem_req_wstrb_o,
           l_valid_o, l_wenReg_o, l_rd_o, l_res_o, l_err_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store pipeline stage. One instruction at a time: memory ops run a single
// request/response transaction, everything else passes straight to write-back.
// A finished instruction retiring to write-back can overlap the next accept.
module lsu #(
  parameter int XLEN   = 32,
  parameter int MASK_W = XLEN / 8
) (
  input logic  clk_i,
  input logic  rst_i,
  lsu_if.slave bus
);

  localparam int OFF_W = $clog2(MASK_W);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state, state_next;

  // Captured instruction fields (only those needed after the accept cycle)
  logic [XLEN-1:0]   cap_res;
  logic [XLEN-1:0]   cap_src2;
  logic [MASK_W-1:0] cap_mask;
  logic              cap_wen_mem;
  logic              cap_signed;
  logic [OFF_W-1:0]  cap_off;

  // Registered write-back fields
  logic              l_wen_reg;
  logic [4:0]        l_rd;
  logic [XLEN-1:0]   l_res;
  logic              l_err;

  // Accept-side decode of the incoming instruction
  logic                accept;
  logic                in_mem;
  logic                in_misaligned;
  logic                go_req;
  logic [OFF_W-1:0]    in_off;
  logic [2*MASK_W-1:0] in_strb_wide;

  // Load data alignment and extension
  logic [XLEN-1:0]   load_sh;
  logic [XLEN-1:0]   load_val;
  logic              req_active;

  assign bus.L_ready_o = (state == IDLE) || ((state == DONE) && bus.w_ready_i);
  assign accept        = bus.m_valid_i && bus.L_ready_o;

  // Shifting the mask into a double-width field exposes lanes past the word
  // boundary; any bit landing there means the access straddles two words.
  assign in_off        = bus.m_res_i[OFF_W-1:0];
  assign in_strb_wide  = {{MASK_W{1'b0}}, bus.m_mask_i} << in_off;
  assign in_misaligned = |in_strb_wide[2*MASK_W-1:MASK_W];
  assign in_mem        = bus.m_wenMem_i || bus.m_renMem_i;
  assign go_req        = in_mem && !in_misaligned;

  assign cap_off       = cap_res[OFF_W-1:0];

  // Request outputs are decoded from the captured fields, so they cannot move
  // while REQ waits for mem_req_ready_i, and read as zero outside REQ.
  assign req_active          = (state == REQ);
  assign bus.mem_req_valid_o = req_active;
  assign bus.mem_req_addr_o  = req_active ? {cap_res[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.mem_req_wen_o   = req_active && cap_wen_mem;
  assign bus.mem_req_wdata_o = req_active ? (cap_src2 << {cap_off, 3'b000}) : '0;
  assign bus.mem_req_wstrb_o = req_active ? (cap_mask << cap_off) : '0;

  assign bus.l_valid_o  = (state == DONE);
  assign bus.l_wenReg_o = l_wen_reg;
  assign bus.l_rd_o     = l_rd;
  assign bus.l_res_o    = l_res;
  assign bus.l_err_o    = l_err;

  assign load_sh = bus.mem_resp_rdata_i >> {cap_off, 3'b000};

  // Select byte/half/word from the lane-shifted read data and extend it
  always_comb begin
    load_val = load_sh;
    if (cap_mask == MASK_W'(1)) begin
      load_val = {{(XLEN-8){cap_signed && load_sh[7]}}, load_sh[7:0]};
    end else if (cap_mask == MASK_W'(3)) begin
      load_val = {{(XLEN-16){cap_signed && load_sh[15]}}, load_sh[15:0]};
    end
  end

  // Next-state logic; a DONE->accept overlap goes straight to the new target
  always_comb begin
    // NOTE: state_next is defaulted before the case so every path assigns it;
    // an unassigned path in always_comb would infer a latch.
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = go_req ? REQ : DONE;
      REQ:  if (bus.mem_req_ready_i) state_next = RESP;
      RESP: if (bus.mem_resp_valid_i) state_next = DONE;
      DONE: begin
        if (accept) state_next = go_req ? REQ : DONE;
        else if (bus.w_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop updates
    // from pre-edge values regardless of block ordering.
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Capture on accept; fill in the result when the memory responds
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cap_res     <= '0;
      cap_src2    <= '0;
      cap_mask    <= '0;
      cap_wen_mem <= 1'b0;
      cap_signed  <= 1'b0;
      l_wen_reg   <= 1'b0;
      l_rd        <= '0;
      l_res       <= '0;
      l_err       <= 1'b0;
    end else if (accept) begin
      cap_res     <= bus.m_res_i;
      cap_src2    <= bus.m_src2_i;
      cap_mask    <= bus.m_mask_i;
      cap_wen_mem <= bus.m_wenMem_i;
      cap_signed  <= bus.m_is_load_signed_i;
      l_wen_reg   <= bus.m_wenReg_i;
      l_rd        <= bus.m_rd_i;
      // Pass-through value; overwritten on response for aligned memory ops
      l_res       <= bus.m_res_i;
      l_err       <= in_mem && in_misaligned;
    end else if ((state == RESP) && bus.mem_resp_valid_i) begin
      l_err <= bus.mem_resp_err_i;
      if (cap_wen_mem)             l_res <= cap_res;
      else if (bus.mem_resp_err_i) l_res <= '0;
      else                         l_res <= load_val;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: hand-computed vector table, multi-cycle corner
// sequences, and random instructions scored against a byte-level model.
module tb_lsu;

  localparam int XLEN   = 32;
  localparam int MASK_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_if #(.XLEN(XLEN), .MASK_W(MASK_W)) bus ();

  lsu #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] src2;
    logic [3:0]  mask;
    logic        wen_mem;
    logic        ren_mem;
    logic        sgn;
    logic        wen_reg;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          req_wait;
    int          resp_wait;
    int          wb_wait;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_err;
    logic [31:0] exp_res;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] res, input logic [31:0] src2, input logic [3:0] mask,
    input logic wm, input logic rm, input logic sg, input logic [4:0] rd,
    input logic [31:0] rdata, input logic err,
    input int rqw, input int rsw, input int wbw,
    input logic ereq, input logic [31:0] eaddr, input logic [31:0] ewdata,
    input logic [3:0] ewstrb, input logic eerr, input logic [31:0] eres);
    vec_t v;
    v.res = res; v.src2 = src2; v.mask = mask; v.wen_mem = wm; v.ren_mem = rm;
    v.sgn = sg; v.wen_reg = !wm; v.rd = rd; v.rdata = rdata; v.err = err;
    v.req_wait = rqw; v.resp_wait = rsw; v.wb_wait = wbw;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_wdata = ewdata;
    v.exp_wstrb = ewstrb; v.exp_err = eerr; v.exp_res = eres;
    return v;
  endfunction

  // Reference model: access size in bytes, byte-lane picking, arithmetic
  // sign extension.
  function automatic vec_t model(input vec_t v);
    int          size;
    int          off;
    logic [63:0] acc;
    size = (v.mask == 4'b1111) ? 4 : (v.mask == 4'b0011) ? 2 : 1;
    off  = int'(v.res[1:0]);
    v.exp_req = 0; v.exp_addr = 0; v.exp_wdata = 0; v.exp_wstrb = 0;
    v.exp_err = 0; v.exp_res = v.res;
    if (!v.wen_mem && !v.ren_mem) return v;
    if (off + size > 4) begin
      v.exp_err = 1;
      return v;
    end
    v.exp_req   = 1;
    v.exp_addr  = v.res - 32'(off);
    v.exp_wdata = v.src2 << (8 * off);
    for (int i = 0; i < size; i++) v.exp_wstrb[off+i] = 1'b1;
    if (v.err) begin
      v.exp_err = 1;
      v.exp_res = v.wen_mem ? v.res : 32'h0;
      return v;
    end
    if (!v.wen_mem) begin
      acc = 0;
      for (int i = 0; i < size; i++) acc += 64'(v.rdata[8*(off+i) +: 8]) << (8 * i);
      if (v.sgn && size < 4 && acc[8*size-1]) acc = acc - (64'd1 << (8 * size));
      v.exp_res = acc[31:0];
    end
    return v;
  endfunction

  task automatic drive_instr(input vec_t v);
    bus.m_valid_i          = 1'b1;
    bus.m_res_i            = v.res;
    bus.m_src2_i           = v.src2;
    bus.m_mask_i           = v.mask;
    bus.m_wenMem_i         = v.wen_mem;
    bus.m_renMem_i         = v.ren_mem;
    bus.m_is_load_signed_i = v.sgn;
    bus.m_wenReg_i         = v.wen_reg;
    bus.m_rd_i             = v.rd;
  endtask

  // Once valid drops, upstream may change its fields freely
  task automatic scramble_m();
    bus.m_valid_i          = 1'b0;
    bus.m_res_i            = $urandom;
    bus.m_src2_i           = $urandom;
    bus.m_mask_i           = 4'($urandom);
    bus.m_wenMem_i         = 1'($urandom);
    bus.m_renMem_i         = 1'($urandom);
    bus.m_is_load_signed_i = 1'($urandom);
    bus.m_wenReg_i         = 1'($urandom);
    bus.m_rd_i             = 5'($urandom);
  endtask

  // Run one instruction from IDLE through write-back, acting as memory and
  // write-back stage; every step is a fixed number of cycles.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    drive_instr(v);
    #1 check({tag, ".ready"}, bus.L_ready_o, 1);
    @(negedge clk);
    scramble_m();
    if (v.exp_req) begin
      check({tag, ".req_ctl"}, {bus.mem_req_valid_o, bus.L_ready_o, bus.mem_req_wen_o, bus.mem_req_wstrb_o},
            {1'b1, 1'b0, v.wen_mem, v.exp_wstrb});
      check({tag, ".req_addr"}, bus.mem_req_addr_o, v.exp_addr);
      check({tag, ".req_wdata"}, bus.mem_req_wdata_o, v.exp_wdata);
      for (int i = 0; i < v.req_wait; i++) begin
        // Response noise while in REQ must be ignored
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_rdata_i = $urandom;
        bus.mem_resp_err_i   = 1'b1;
        @(negedge clk);
        check({tag, ".hold_ctl"}, {bus.mem_req_valid_o, bus.mem_req_wen_o, bus.mem_req_wstrb_o},
              {1'b1, v.wen_mem, v.exp_wstrb});
        check({tag, ".hold_data"}, {bus.mem_req_addr_o, bus.mem_req_wdata_o}, {v.exp_addr, v.exp_wdata});
      end
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_err_i   = 1'b0;
      bus.mem_req_ready_i  = 1'b1;
      @(negedge clk);
      bus.mem_req_ready_i = 1'b0;
      check({tag, ".resp_wait"}, {bus.mem_req_valid_o, bus.l_valid_o}, 2'b00);
      for (int i = 0; i < v.resp_wait; i++) begin
        @(negedge clk);
        check({tag, ".resp_idle"}, {bus.mem_req_valid_o, bus.l_valid_o}, 2'b00);
      end
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_rdata_i = v.rdata;
      bus.mem_resp_err_i   = v.err;
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_rdata_i = $urandom;
      bus.mem_resp_err_i   = 1'b0;
    end else begin
      check({tag, ".no_req"}, bus.mem_req_valid_o, 0);
    end
    check({tag, ".l_valid"}, bus.l_valid_o, 1);
    check({tag, ".l_res"}, bus.l_res_o, v.exp_res);
    check({tag, ".l_meta"}, {bus.l_err_o, bus.l_wenReg_o, bus.l_rd_o}, {v.exp_err, v.wen_reg, v.rd});
    for (int i = 0; i < v.wb_wait; i++) begin
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_err_i   = !v.exp_err;
      @(negedge clk);
      check({tag, ".bp_ctl"}, {bus.l_valid_o, bus.L_ready_o, bus.mem_req_valid_o, bus.l_err_o, bus.l_wenReg_o, bus.l_rd_o},
            {1'b1, 1'b0, 1'b0, v.exp_err, v.wen_reg, v.rd});
      check({tag, ".bp_res"}, bus.l_res_o, v.exp_res);
    end
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_err_i   = 1'b0;
    bus.w_ready_i = 1'b1;
    @(negedge clk);
    bus.w_ready_i = 1'b0;
    check({tag, ".retired"}, bus.l_valid_o, 0);
  endtask

  initial begin
    vec_t tbl [13];
    vec_t v;

    bus.m_valid_i = 0; bus.m_res_i = 0; bus.m_src2_i = 0; bus.m_mask_i = 0;
    bus.m_wenMem_i = 0; bus.m_renMem_i = 0; bus.m_is_load_signed_i = 0;
    bus.m_wenReg_i = 0; bus.m_rd_i = 0;
    bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 0; bus.mem_resp_rdata_i = 0;
    bus.mem_resp_err_i = 0; bus.w_ready_i = 0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.l_valid", bus.l_valid_o, 0);
    check("reset.L_ready", bus.L_ready_o, 1);
    check("reset.l_fields", {bus.l_err_o, bus.l_wenReg_o, bus.l_rd_o, bus.l_res_o}, 0);
    check("reset.req", {bus.mem_req_valid_o, bus.mem_req_wen_o, bus.mem_req_wstrb_o, bus.mem_req_addr_o}, 0);
    rst_n = 1'b1;

    //          res            src2           mask     wm rm sg rd  rdata          err rq rs wb  req addr           wdata          wstrb    err res
    tbl[0]  = mk(32'h1234,     32'h0,         4'b0000, 0, 0, 0, 5,  32'h0,         0,  0, 0, 0,  0, 32'h0,        32'h0,         4'b0000, 0, 32'h1234);
    tbl[1]  = mk(32'h80000003, 32'h0,         4'b0001, 0, 1, 1, 7,  32'h85FFFFFF,  0,  0, 0, 0,  1, 32'h80000000, 32'h0,         4'b1000, 0, 32'hFFFFFF85);
    tbl[2]  = mk(32'h80000003, 32'h0,         4'b0001, 0, 1, 0, 8,  32'h85FFFFFF,  0,  0, 0, 0,  1, 32'h80000000, 32'h0,         4'b1000, 0, 32'h00000085);
    tbl[3]  = mk(32'h102,      32'hABCD,      4'b0011, 1, 0, 0, 0,  32'h0,         0,  3, 0, 0,  1, 32'h100,      32'hABCD0000,  4'b1100, 0, 32'h102);
    tbl[4]  = mk(32'h101,      32'h0,         4'b1111, 0, 1, 0, 9,  32'h0,         0,  0, 0, 0,  0, 32'h0,        32'h0,         4'b0000, 1, 32'h101);
    tbl[5]  = mk(32'h200,      32'h0,         4'b1111, 0, 1, 1, 10, 32'hDEADBEEF,  1,  0, 1, 0,  1, 32'h200,      32'h0,         4'b1111, 1, 32'h0);
    tbl[6]  = mk(32'h2,        32'h0,         4'b0011, 0, 1, 1, 11, 32'h80011234,  0,  0, 0, 0,  1, 32'h0,        32'h0,         4'b1100, 0, 32'hFFFF8001);
    tbl[7]  = mk(32'h2,        32'h0,         4'b0011, 0, 1, 0, 13, 32'h80011234,  0,  0, 0, 0,  1, 32'h0,        32'h0,         4'b1100, 0, 32'h00008001);
    tbl[8]  = mk(32'h4,        32'h55,        4'b1111, 0, 1, 0, 12, 32'h12345678,  0,  1, 2, 4,  1, 32'h4,        32'h55,        4'b1111, 0, 32'h12345678);
    tbl[9]  = mk(32'h1,        32'h123456AB,  4'b0001, 1, 0, 0, 0,  32'h0,         0,  0, 0, 0,  1, 32'h0,        32'h3456AB00,  4'b0010, 0, 32'h1);
    tbl[10] = mk(32'h3,        32'h77,        4'b0011, 1, 0, 0, 0,  32'h0,         0,  0, 0, 0,  0, 32'h0,        32'h0,         4'b0000, 1, 32'h3);
    tbl[11] = mk(32'h40,       32'h99,        4'b1111, 1, 0, 0, 0,  32'h0,         1,  0, 0, 0,  1, 32'h40,       32'h99,        4'b1111, 1, 32'h40);
    tbl[12] = mk(32'h3,        32'h0,         4'b1111, 0, 0, 0, 3,  32'h0,         0,  0, 0, 4,  0, 32'h0,        32'h0,         4'b0000, 0, 32'h3);

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back pass-through: three instructions retire in three cycles
    @(negedge clk);
    bus.w_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.m_valid_i = 1'b1; bus.m_wenMem_i = 0; bus.m_renMem_i = 0; bus.m_wenReg_i = 1;
      bus.m_res_i = 32'h1000 + 32'(i); bus.m_rd_i = 5'(i + 1);
      #1 check("b2b.ready", bus.L_ready_o, 1);
      @(negedge clk);
      check("b2b.out", {bus.l_valid_o, bus.l_rd_o, bus.l_res_o}, {1'b1, 5'(i + 1), 32'h1000 + 32'(i)});
    end
    bus.m_valid_i = 1'b0;
    @(negedge clk);
    check("b2b.idle", bus.l_valid_o, 0);
    bus.w_ready_i = 1'b0;

    // Backpressure with a waiting instruction, then same-cycle retire+accept
    @(negedge clk);
    bus.m_valid_i = 1'b1; bus.m_wenMem_i = 0; bus.m_renMem_i = 0; bus.m_wenReg_i = 1;
    bus.m_res_i = 32'hA0A0; bus.m_rd_i = 5'd1;
    @(negedge clk);
    bus.m_res_i = 32'hB0B0; bus.m_rd_i = 5'd2;
    for (int i = 0; i < 4; i++) begin
      #1 check("bp.hold", {bus.L_ready_o, bus.l_valid_o, bus.l_rd_o, bus.l_res_o}, {1'b0, 1'b1, 5'd1, 32'hA0A0});
      @(negedge clk);
    end
    bus.w_ready_i = 1'b1;
    #1 check("bp.ready", bus.L_ready_o, 1);
    @(negedge clk);
    bus.m_valid_i = 1'b0;
    check("bp.next", {bus.l_valid_o, bus.l_rd_o, bus.l_res_o}, {1'b1, 5'd2, 32'hB0B0});
    @(negedge clk);
    check("bp.idle", bus.l_valid_o, 0);
    bus.w_ready_i = 1'b0;

    // Random instructions against the model
    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 2);
      v.res  = $urandom;
      v.src2 = $urandom;
      case ($urandom_range(0, 2))
        0:       v.mask = 4'b0001;
        1:       v.mask = 4'b0011;
        default: v.mask = 4'b1111;
      endcase
      v.wen_mem   = (k == 2);
      v.ren_mem   = (k == 1);
      v.sgn       = 1'($urandom);
      v.wen_reg   = 1'($urandom);
      v.rd        = 5'($urandom);
      v.rdata     = $urandom;
      v.err       = ($urandom_range(0, 7) == 0);
      v.req_wait  = $urandom_range(0, 2);
      v.resp_wait = $urandom_range(0, 2);
      v.wb_wait   = $urandom_range(0, 2);
      v = model(v);
      run_vec("rnd", v);
    end

    // Reset during RESP abandons the load; a late response is ignored
    @(negedge clk);
    v = model(mk(32'h10, 32'h0, 4'b1111, 0, 1, 0, 17, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_instr(v);
    @(negedge clk);
    scramble_m();
    check("rst.req", bus.mem_req_valid_o, 1);
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    check("rst.in_resp", {bus.mem_req_valid_o, bus.l_valid_o, bus.l_rd_o}, {1'b0, 1'b0, 5'd17});
    rst_n = 1'b0;
    #1;
    check("rst.outs", {bus.l_valid_o, bus.l_err_o, bus.l_wenReg_o, bus.l_rd_o, bus.mem_req_valid_o}, 0);
    check("rst.res", bus.l_res_o, 0);
    check("rst.ready", bus.L_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    check("rst.late_resp", {bus.l_valid_o, bus.mem_req_valid_o}, 2'b00);
    @(negedge clk);
    check("rst.no_reissue", {bus.l_valid_o, bus.mem_req_valid_o, bus.L_ready_o}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
